// File: rtl/dual_grant_arbiter_if.sv
// Request/grant bundle between the client blocks and the two-channel arbiter.
// The master side drives requests and channel completions; the slave side
// (the arbiter) returns the registered grant state.
interface dual_grant_arbiter_if #(
    parameter int N   = 12,
    parameter int IDW = 4
) ();
    logic [N-1:0]   req;
    logic           done_a;
    logic           done_b;
    logic [IDW-1:0] gnt_a_id;
    logic [IDW-1:0] gnt_b_id;
    logic           busy_a;
    logic           busy_b;
    logic [N-1:0]   gnt_vec;

    modport master (
        output req, done_a, done_b,
        input  gnt_a_id, gnt_b_id, busy_a, busy_b, gnt_vec
    );

    modport slave (
        input  req, done_a, done_b,
        output gnt_a_id, gnt_b_id, busy_a, busy_b, gnt_vec
    );
endinterface

// File: rtl/dual_grant_arbiter.sv
// Two-channel rotating-priority arbiter. Each arbitration cycle scans the
// eligible requesters downward from ptr (with wrap) and hands the first and
// second hits to whichever channels are idle. Grants are held until the
// owning channel pulses its done; grant ids are index+1, with 0 meaning none.
module dual_grant_arbiter #(
    parameter int N   = 12,
    parameter int IDW = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    dual_grant_arbiter_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        CH_IDLE  = 1'b0,
        CH_GRANT = 1'b1
    } chan_state_e;

    // Registered state and outputs
    chan_state_e    state_a_q, state_a_d;
    chan_state_e    state_b_q, state_b_d;
    logic [IDW-1:0] gnt_a_id_q, gnt_a_id_d;
    logic [IDW-1:0] gnt_b_id_q, gnt_b_id_d;
    logic           busy_a_q, busy_a_d;
    logic           busy_b_q, busy_b_d;
    logic [N-1:0]   gnt_vec_q, gnt_vec_d;
    logic [PW-1:0]  ptr_q, ptr_d;

    // Combinational arbitration results
    logic [N-1:0]   eligible;
    logic           first_found, second_found;
    logic [PW-1:0]  first_idx, second_idx;
    logic           a_take, b_take;
    logic [PW-1:0]  b_idx, last_idx;
    logic           rel_a, rel_b;

    // A requester already holding a channel is never offered the other one.
    assign eligible = bus.req & ~gnt_vec_q;

    // Dual scan: find the first two eligible requesters in the order ptr, ptr-1, ..., wrapping.
    always_comb begin
        int            pos;
        logic [PW-1:0] idx;
        // NOTE: every variable driven here gets a default before any branch, otherwise a latch is inferred.
        pos          = 0;
        idx          = '0;
        first_found  = 1'b0;
        second_found = 1'b0;
        first_idx    = '0;
        second_idx   = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr_q) - k;
            if (pos < 0) begin
                pos = pos + N;
            end
            idx = PW'(pos);
            if (eligible[idx]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_idx   = idx;
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_idx   = idx;
                end
            end
        end
    end

    // Assignment to idle channels, release on done, pointer update and next-state values.
    always_comb begin
        // A releasing channel is still in GRANT this cycle, so it cannot be re-granted on the same edge.
        rel_a  = (state_a_q == CH_GRANT) && bus.done_a;
        rel_b  = (state_b_q == CH_GRANT) && bus.done_b;

        a_take = (state_a_q == CH_IDLE) && first_found;
        b_take = 1'b0;
        b_idx  = first_idx;
        if (state_b_q == CH_IDLE) begin
            if (state_a_q == CH_IDLE) begin
                // A takes the first hit, so B gets the second.
                b_take = second_found;
                b_idx  = second_idx;
            end else begin
                b_take = first_found;
                b_idx  = first_idx;
            end
        end

        // The last assignment in scan order is the lowest-priority one; B is always later than A.
        last_idx = b_take ? b_idx : first_idx;
        ptr_d    = ptr_q;
        if (a_take || b_take) begin
            ptr_d = (last_idx == '0) ? PW'(N - 1) : (last_idx - PW'(1));
        end

        state_a_d  = state_a_q;
        gnt_a_id_d = gnt_a_id_q;
        if (rel_a) begin
            state_a_d  = CH_IDLE;
            gnt_a_id_d = '0;
        end else if (a_take) begin
            state_a_d  = CH_GRANT;
            gnt_a_id_d = IDW'(first_idx) + IDW'(1);
        end

        state_b_d  = state_b_q;
        gnt_b_id_d = gnt_b_id_q;
        if (rel_b) begin
            state_b_d  = CH_IDLE;
            gnt_b_id_d = '0;
        end else if (b_take) begin
            state_b_d  = CH_GRANT;
            gnt_b_id_d = IDW'(b_idx) + IDW'(1);
        end

        busy_a_d = (state_a_d == CH_GRANT);
        busy_b_d = (state_b_d == CH_GRANT);

        gnt_vec_d = gnt_vec_q;
        for (int i = 0; i < N; i++) begin
            if (rel_a && (gnt_a_id_q == IDW'(i + 1))) begin
                gnt_vec_d[i] = 1'b0;
            end
            if (rel_b && (gnt_b_id_q == IDW'(i + 1))) begin
                gnt_vec_d[i] = 1'b0;
            end
            if (a_take && (first_idx == PW'(i))) begin
                gnt_vec_d[i] = 1'b1;
            end
            if (b_take && (b_idx == PW'(i))) begin
                gnt_vec_d[i] = 1'b1;
            end
        end
    end

    // Channel FSMs, pointer and registered outputs; reset drops every grant at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_a_q  <= CH_IDLE;
            state_b_q  <= CH_IDLE;
            gnt_a_id_q <= '0;
            gnt_b_id_q <= '0;
            busy_a_q   <= 1'b0;
            busy_b_q   <= 1'b0;
            gnt_vec_q  <= '0;
            ptr_q      <= PW'(N - 1);
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update from the same pre-edge values.
            state_a_q  <= state_a_d;
            state_b_q  <= state_b_d;
            gnt_a_id_q <= gnt_a_id_d;
            gnt_b_id_q <= gnt_b_id_d;
            busy_a_q   <= busy_a_d;
            busy_b_q   <= busy_b_d;
            gnt_vec_q  <= gnt_vec_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.gnt_a_id = gnt_a_id_q;
    assign bus.gnt_b_id = gnt_b_id_q;
    assign bus.busy_a   = busy_a_q;
    assign bus.busy_b   = busy_b_q;
    assign bus.gnt_vec  = gnt_vec_q;

endmodule

// File: tb/tb_dual_grant_arbiter.sv
// Self-checking bench for dual_grant_arbiter: directed scenarios plus a
// random phase, all observed outputs compared against a queue of expected
// values produced by a behavioural reference model.
module tb_dual_grant_arbiter;
    localparam int N   = 12;
    localparam int IDW = 4;

    typedef struct {
        int a_id;
        int b_id;
        int busy_a;
        int busy_b;
        int vec;
    } exp_t;

    logic clk;
    logic rst_n;

    dual_grant_arbiter_if #(.N(N), .IDW(IDW)) bus ();

    dual_grant_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    // Reference model state: owner index per channel (-1 = none) and scan pointer.
    int m_a;
    int m_b;
    int m_ptr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_a   = -1;
        m_b   = -1;
        m_ptr = N - 1;
    endfunction

    // One rising edge of the reference: release first, then fill idle channels from the candidate list.
    function automatic void model_edge(input logic [N-1:0] r, input logic da, input logic db);
        int  cand[$];
        int  na;
        int  nb;
        int  last;
        bit  a_idle;
        bit  b_idle;
        int  i;
        na     = m_a;
        nb     = m_b;
        last   = -1;
        a_idle = (m_a < 0);
        b_idle = (m_b < 0);
        if (!a_idle && da) na = -1;
        if (!b_idle && db) nb = -1;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr - k + N) % N;
            if (r[i] && i != m_a && i != m_b) cand.push_back(i);
        end
        if (a_idle && cand.size() > 0) begin
            na   = cand.pop_front();
            last = na;
        end
        if (b_idle && cand.size() > 0) begin
            nb   = cand.pop_front();
            last = nb;
        end
        if (last >= 0) m_ptr = (last + N - 1) % N;
        m_a = na;
        m_b = nb;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   v;
        v        = 0;
        e.a_id   = m_a + 1;
        e.b_id   = m_b + 1;
        e.busy_a = int'(m_a >= 0);
        e.busy_b = int'(m_b >= 0);
        if (m_a >= 0) v = v | (1 << m_a);
        if (m_b >= 0) v = v | (1 << m_b);
        e.vec = v;
        return e;
    endfunction

    // Hold reset with the given request pattern, check outputs, release at a falling edge.
    task automatic do_reset(input logic [N-1:0] r);
        rst_n      = 1'b0;
        bus.req    = r;
        bus.done_a = 1'b0;
        bus.done_b = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_id",   int'(bus.gnt_a_id), 0);
        check("rst_b_id",   int'(bus.gnt_b_id), 0);
        check("rst_busy_a", int'(bus.busy_a),   0);
        check("rst_busy_b", int'(bus.busy_b),   0);
        check("rst_vec",    int'(bus.gnt_vec),  0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle of stimulus (caller sits between edges), score the result after the edge.
    task automatic step(input logic [N-1:0] r, input logic da, input logic db);
        exp_t e;
        bus.req    = r;
        bus.done_a = da;
        bus.done_b = db;
        model_edge(r, da, db);
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("sb_a_id",   int'(bus.gnt_a_id), e.a_id);
        check("sb_b_id",   int'(bus.gnt_b_id), e.b_id);
        check("sb_busy_a", int'(bus.busy_a),   e.busy_a);
        check("sb_busy_b", int'(bus.busy_b),   e.busy_b);
        check("sb_vec",    int'(bus.gnt_vec),  e.vec);
        @(negedge clk);
    endtask

    initial begin
        int             hold_a;
        int             hold_b;
        logic [IDW-1:0] prev_a;
        logic [IDW-1:0] prev_b;
        int             seen[$];

        rst_n      = 1'b0;
        bus.req    = '0;
        bus.done_a = 1'b0;
        bus.done_b = 1'b0;
        model_reset();

        // Reset with everyone requesting, then first arbitration from ptr = N-1.
        do_reset(12'hFFF);
        step(12'hFFF, 1'b0, 1'b0);
        check("rel_a_id", int'(bus.gnt_a_id), 12);
        check("rel_b_id", int'(bus.gnt_b_id), 11);
        check("rel_vec",  int'(bus.gnt_vec),  'hC00);

        // Dual grant from idle.
        do_reset(12'h000);
        step(12'h820, 1'b0, 1'b0);
        check("dual_a_id",  int'(bus.gnt_a_id), 12);
        check("dual_b_id",  int'(bus.gnt_b_id), 6);
        check("dual_busyA", int'(bus.busy_a),   1);
        check("dual_busyB", int'(bus.busy_b),   1);

        // Release A; the one-cycle gap, then A goes to requester 0 (bit 5 still held by B).
        step(12'h821, 1'b1, 1'b0);
        check("relA_busy", int'(bus.busy_a),  0);
        check("relA_vec",  int'(bus.gnt_vec), 'h020);
        step(12'h821, 1'b0, 1'b0);
        check("regrant_a", int'(bus.gnt_a_id), 1);
        check("regrant_v", int'(bus.gnt_vec),  'h021);

        // Grants survive dropped requests until done.
        for (int c = 0; c < 10; c++) begin
            step(12'h000, 1'b0, 1'b0);
            check("hold_a", int'(bus.gnt_a_id), 1);
            check("hold_b", int'(bus.gnt_b_id), 6);
        end
        step(12'h000, 1'b1, 1'b1);
        check("both_rel_a", int'(bus.gnt_a_id), 0);
        check("both_rel_b", int'(bus.gnt_b_id), 0);
        check("both_rel_v", int'(bus.gnt_vec),  0);

        // Done on idle channels is ignored; grant at index 0 wraps ptr.
        step(12'h001, 1'b0, 1'b1);
        check("wrap_a_id", int'(bus.gnt_a_id), 1);
        check("wrap_b_id", int'(bus.gnt_b_id), 0);

        // Asynchronous reset between edges while A is busy.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_a_id",   int'(bus.gnt_a_id), 0);
        check("async_b_id",   int'(bus.gnt_b_id), 0);
        check("async_busy_a", int'(bus.busy_a),   0);
        check("async_busy_b", int'(bus.busy_b),   0);
        check("async_vec",    int'(bus.gnt_vec),  0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(12'h003, 1'b0, 1'b0);
        check("post_rst_a", int'(bus.gnt_a_id), 2);
        check("post_rst_b", int'(bus.gnt_b_id), 1);

        // Fairness: everyone requesting, each grant completed after two cycles.
        do_reset(12'hFFF);
        hold_a = 0;
        hold_b = 0;
        prev_a = '0;
        prev_b = '0;
        for (int c = 0; c < 200 && seen.size() < N; c++) begin
            step(12'hFFF, hold_a >= 2, hold_b >= 2);
            if (bus.gnt_a_id != '0 && prev_a == '0) seen.push_back(int'(bus.gnt_a_id));
            if (bus.gnt_b_id != '0 && prev_b == '0) seen.push_back(int'(bus.gnt_b_id));
            prev_a = bus.gnt_a_id;
            prev_b = bus.gnt_b_id;
            hold_a = bus.busy_a ? hold_a + 1 : 0;
            hold_b = bus.busy_b ? hold_b + 1 : 0;
        end
        check("fair_cnt", int'(seen.size() >= N), 1);
        for (int i = 0; i < N && i < seen.size(); i++) begin
            check("fair_ord", seen[i], N - i);
        end

        // Random requests and done pulses, including done on idle channels.
        do_reset(12'h000);
        for (int c = 0; c < 400; c++) begin
            step(N'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_grant_arbiter.md
# dual_grant_arbiter

- Shares two identical service channels, A and B, among N requesters.
- Uses a rotating-priority dual scan: each arbitration cycle finds the first and second eligible requesters.
- Holds each grant until the owning channel signals completion.
- Sits between the request lines of the client blocks and the two-channel resource. Grant identities use the codebase's priority-encoder convention: index+1, with 0 meaning none.

## Interface
- N, 12, number of requesters (2..15).
- IDW, 4, grant id width; must satisfy 2^IDW > N.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  level request per requester; bit i = requester i.
- done_a  input  1  one-cycle pulse: channel A finished its current grant.
- done_b  input  1  one-cycle pulse: channel B finished its current grant.
- gnt_a_id  output  IDW  registered; index+1 of the requester holding A, 0 = none.
- gnt_b_id  output  IDW  registered; index+1 of the requester holding B, 0 = none.
- busy_a  output  1  registered; A holds a grant.
- busy_b  output  1  registered; B holds a grant.
- gnt_vec  output  N  registered; bit i set while requester i holds either channel; at most 2 bits set.

## Operation
- Each channel has a 2-state FSM:
  - IDLE → GRANT when it is assigned a requester at an edge.
  - GRANT → IDLE on the edge where its done is sampled high.
- Eligible set = req with bits currently in gnt_vec masked off. A requester never holds both channels.
- Scan order starts at pointer ptr and descends with wrap: ptr, ptr-1, …, 0, N-1, …, ptr+1.
- Assignment among channels in IDLE:
  - Both IDLE: A takes the first eligible found, B takes the second.
  - Only one IDLE: that channel takes the first eligible found.
  - No eligible bits: no change.
- Pointer update: after any assignment, ptr ← (lowest-priority assigned index in this cycle's scan order) − 1, mod N. Unchanged if nothing is assigned.
- Grants are held regardless of req. Dropping req while granted does not release the grant; only done releases it.
- done on an IDLE channel is ignored.
- A channel released by done stays IDLE for that edge. Re-arbitration for it happens on the following edge, giving a minimum one-cycle gap between successive grants on a channel.
- Scan, eligibility and assignment decisions are combinational from registered state and req. All outputs are registers.

## Timing
- Reset (rst_n low, asynchronous):
  - gnt_a_id=0, gnt_b_id=0, busy_a=0, busy_b=0, gnt_vec=0, ptr=N-1, both FSMs IDLE.
  - Deassertion is synchronous to clk (external synchronizer). Arbitration begins on the first edge after release.
- Grant latency: req sampled at edge k yields gnt_*_id/busy/gnt_vec updated at edge k (visible in cycle k+1).
- done sampled at edge k: that channel's id, busy and gnt_vec bit clear at edge k. New grant no earlier than edge k+1.
- Simultaneous done_a and done_b: both release at the same edge; both may be re-granted together at the next edge.
- done on one channel while the other is IDLE: the IDLE channel may still be granted at that edge. The releasing requester is still masked at that edge.
- Reset mid-grant: all grants drop immediately; pending requests are re-arbitrated from ptr=N-1.
- Pointer wrap: ptr=0 with a grant at index 0 → ptr=N-1.

## Test plan
- Reset: hold rst_n=0 with req=12'hFFF → all outputs 0. Release → next edge gnt_a_id=12, gnt_b_id=11, gnt_vec=12'hC00, ptr=9.
- Dual grant from idle: req=12'h820 → gnt_a_id=12, gnt_b_id=6, busy_a=busy_b=1, ptr=4.
- Hold and release: from the previous state, set req=12'h821, pulse done_a 1 cycle → next edge busy_a=0, gnt_vec=12'h020. Following edge gnt_a_id=1 (bit 5 masked), ptr=11.
- Grant holding: drop req to 0 while both granted → ids unchanged for 10 cycles until done. Pulse done_a and done_b together → both ids 0 at the same edge.
- Wrap and fairness: req=12'hFFF, each grant completed after 2 cycles → every index 12..1 appears on A or B within 6 grant rounds, with no index granted twice before all are served.
- Async reset mid-grant: assert rst_n low between edges while busy_a=1 → outputs 0 immediately, before the next clk edge.
